shift_register_param: RTL
=========================

Name: shift_register_param

Overview:
- Parametrised universal shift register: serial/parallel in, parallel and serial out.
- Generalises the fixed 4-bit serial-in register to any WIDTH.
- Adds mode select (hold, shift right, shift left, parallel load), clock enable, and a bit counter that flags each completed word.
- Sits between a serial bit source and word-wide consumers, i.e. it is the deserialiser/serialiser front end.

Parameters:
- WIDTH, 4, register width in bits; legal range ≥2.
- RESET_VAL, {WIDTH{1'b0}}, register contents after reset.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. 0 = reset.
- en  input  1  clock enable; 0 = hold everything.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- d_in  input  1  serial input bit.
- par_in  input  WIDTH  parallel load data.
- out  output  WIDTH  register contents (registered).
- ser_out  output  1  bit shifted out on the last shift (registered).
- word_valid  output  1  one-cycle pulse: WIDTH shifts completed since last load/reset.
- bit_cnt  output  CNT_W  shifts accumulated in the current word.

Behaviour:
- Reset, asynchronous, immediate on reset=0, including mid-word:
  - out=RESET_VAL
  - ser_out=0
  - word_valid=0
  - bit_cnt=0
- All updates happen on the rising clk edge with reset=1.
- en=0 or mode=00: out, ser_out and bit_cnt hold; word_valid=0.
- mode=01 (shift right):
  - out <= {d_in, out[WIDTH-1:1]}
  - ser_out <= out[0]
- mode=10 (shift left):
  - out <= {out[WIDTH-2:0], d_in}
  - ser_out <= out[WIDTH-1]
- mode=11 (parallel load):
  - out <= par_in
  - bit_cnt <= 0
  - word_valid <= 0
  - ser_out holds
- Counting, per shift (mode 01/10 with en=1):
  - If bit_cnt==WIDTH-1: bit_cnt wraps to 0 and word_valid <= 1. word_valid is high during the cycle after the completing edge; out then holds the full word.
  - Otherwise: bit_cnt increments and word_valid <= 0.
- Latency: one clock from d_in/par_in to out. word_valid is coincident with the completed word on out.
- Mode change between shift directions mid-word: bit_cnt keeps counting; no flush.
- Back-to-back words: a shift in the cycle word_valid is high starts the next word (bit_cnt 0→1). word_valid deasserts unless WIDTH shifts have completed again.
- Load in the same cycle a word would complete: load wins; no word_valid.
- No internal state other than out, ser_out, bit_cnt, word_valid.

Optional Feature:
- Macro: SHIFT_REG_PARITY_EN.
- Defined:
  - Extra output port parity (1 bit) = even parity (XOR reduction) of out.
  - Combinational from out, so 0 while out=RESET_VAL=0 during reset.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package shift_reg_pkg:
  - 2-bit mode typedef with constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
  - Default WIDTH constant.
- Natural sub-module: shift_bit_counter, holding bit_cnt, wrap and word_valid generation.
  - Inputs: shift strobe, clear.
  - Outputs: bit_cnt, word_valid.
- The datapath stays in the top module.

Test Plan (WIDTH=4, RESET_VAL=0):
1. reset=0 at t=0, released after the first edge → out=0000, ser_out=0, word_valid=0, bit_cnt=0 throughout reset. Asynchronous clear is visible before any clk edge.
2. mode=01, en=1, d_in=1,0,1,1 on four edges → out=1000, 0100, 1010, 1101. bit_cnt=1,2,3,0. word_valid=1 only after the fourth edge, for one cycle.
3. mode=11 par_in=0110, then mode=10 d_in=1 → out=0110, then 1101. ser_out=0, bit_cnt=1, word_valid=0.
4. With out=1101, hold for 3 cycles (en=0, then mode=00) → out, ser_out and bit_cnt unchanged; word_valid=0.
5. After two shifts, pulse reset=0 between edges → out=0000 and bit_cnt=0 immediately. Four further shifts are needed before word_valid pulses.
6. SHIFT_REG_PARITY_EN defined, load 0111 then 0110 → parity=1, then 0. Bench also compiles with the macro undefined and passes scenarios 1–5.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared mode encoding and default width for the universal shift register.
package shift_reg_pkg;
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;
  localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/shift_bit_counter.sv
// shift_bit_counter: counts shifts within a word and pulses word_valid on each completed word.
// Ports: clk, reset (async, active-low), shift (one shift this edge), clear (restart word),
//        bit_cnt (shifts in current word), word_valid (one-cycle completed-word pulse).
module shift_bit_counter
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             clear,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_valid
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  logic last;
  assign last = bit_cnt == LAST;
  // clear has priority so a load landing on the completing shift suppresses word_valid
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bit_cnt    <= '0;
      word_valid <= 1'b0;
    end else begin
      bit_cnt    <= clear ? '0 : shift ? (last ? '0 : bit_cnt + CNT_W'(1)) : bit_cnt;
      word_valid <= !clear && shift && last;
    end
endmodule

// File: rtl/shift_register_param.sv
// shift_register_param: universal WIDTH-bit shift register (hold / shift right / shift left / load).
// Ports: clk, reset (async, active-low), en (clock enable), mode (mode_t), d_in (serial in),
//        par_in (parallel load), out (contents), ser_out (bit shifted out last),
//        word_valid (WIDTH shifts completed), bit_cnt (shifts in current word),
//        parity (XOR of out, only when SHIFT_REG_PARITY_EN is defined).
module shift_register_param
  import shift_reg_pkg::*;
#(
  parameter  int               WIDTH     = DEF_WIDTH,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int               CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  mode_t            mode,
  input  logic             d_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] out,
  output logic             ser_out,
  output logic             word_valid,
  output logic [CNT_W-1:0] bit_cnt
`ifdef SHIFT_REG_PARITY_EN
  ,
  output logic             parity
`endif
);
  logic shift, load;
  assign shift = en && (mode == MODE_SHR || mode == MODE_SHL);
  assign load  = en && mode == MODE_LOAD;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out     <= RESET_VAL;
      ser_out <= 1'b0;
    end else if (load) begin
      out <= par_in;
    end else if (shift) begin
      out     <= mode == MODE_SHR ? {d_in, out[WIDTH-1:1]} : {out[WIDTH-2:0], d_in};
      ser_out <= mode == MODE_SHR ? out[0] : out[WIDTH-1];
    end
  shift_bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .shift      (shift),
    .clear      (load),
    .bit_cnt    (bit_cnt),
    .word_valid (word_valid)
  );
`ifdef SHIFT_REG_PARITY_EN
  assign parity = ^out;
`endif
endmodule
